pe_grid_mc: RTL and testbench

Parametrised ROWS×COLS processing-element grid with tag-matched multicast delivery and end-of-pass vertical psum reduction. Weight and image packets arrive on two independent valid/ready buses. Each packet carries a (row_tag, col_tag) pair and is delivered in one transfer to every PE whose runtime-configured IDs match. Each PE multiply-accumulates locally. On a drain request, column partial sums are reduced bottom-to-top into a registered, handshaked output word.

---
 rtl/pe_grid_mc.sv | 206 ++++++++++++++++++++
 tb/tb_pe_grid_mc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_grid_mc.sv
// pe_grid_mc: ROWS x COLS multiply-accumulate grid with tag-matched multicast loading
// and end-of-pass column reduction. Define PE_GRID_DROP_CNT_EN to build the drop counter.
module pe_grid_mc #(
  parameter int ROWS   = 12,
  parameter int COLS   = 14,
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32,
  parameter int ID_W   = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  input  logic [RW-1:0]          cfg_r,
  input  logic [CW-1:0]          cfg_c,
  input  logic [ID_W-1:0]        cfg_row_id,
  input  logic [ID_W-1:0]        cfg_col_id,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_W-1:0]      w_data,
  input  logic [ID_W-1:0]        w_row_tag,
  input  logic [ID_W-1:0]        w_col_tag,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [DATA_W-1:0]      i_data,
  input  logic [ID_W-1:0]        i_row_tag,
  input  logic [ID_W-1:0]        i_col_tag,
  input  logic                   drain_req,
  input  logic [COLS*PSUM_W-1:0] psum_in,
  output logic [COLS*PSUM_W-1:0] psum_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_REDUCE, S_OUT} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   k_q, k_d;
  logic [RW-1:0]   red_row;
  logic            run, mac_en, acc_clr;
  logic            w_block, i_block, w_any, i_any;
  logic            w_fire, i_fire, cfg_we;

  logic [ID_W-1:0]          row_id_q [ROWS][COLS];
  logic [ID_W-1:0]          col_id_q [ROWS][COLS];
  logic                     w_full_q [ROWS][COLS];
  logic                     i_full_q [ROWS][COLS];
  logic signed [DATA_W-1:0] w_data_q [ROWS][COLS];
  logic signed [DATA_W-1:0] i_data_q [ROWS][COLS];
  logic [PSUM_W-1:0]        acc_q    [ROWS][COLS];
  logic [PSUM_W-1:0]        prod     [ROWS][COLS];
  logic                     w_match  [ROWS][COLS];
  logic                     i_match  [ROWS][COLS];
  logic [PSUM_W-1:0]        preg_q   [COLS];

  // Ready is withheld only by matching PEs whose slot is still occupied.
  always_comb begin
    w_block = 1'b0;
    i_block = 1'b0;
    w_any   = 1'b0;
    i_any   = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        w_match[r][c] = ((w_row_tag == row_id_q[r][c]) || (w_row_tag == '1)) &&
                        ((w_col_tag == col_id_q[r][c]) || (w_col_tag == '1));
        i_match[r][c] = ((i_row_tag == row_id_q[r][c]) || (i_row_tag == '1)) &&
                        ((i_col_tag == col_id_q[r][c]) || (i_col_tag == '1));
        w_block = w_block | (w_match[r][c] & w_full_q[r][c]);
        i_block = i_block | (i_match[r][c] & i_full_q[r][c]);
        w_any   = w_any | w_match[r][c];
        i_any   = i_any | i_match[r][c];
        prod[r][c] = PSUM_W'(w_data_q[r][c] * i_data_q[r][c]);
      end
    end
  end

  assign run     = (state_q == S_RUN);
  assign w_ready = rst & run & ~w_block;
  assign i_ready = rst & run & ~i_block;
  assign w_fire  = w_valid & w_ready;
  assign i_fire  = i_valid & i_ready;
  assign cfg_we  = cfg_valid & run;
  assign red_row = RW'(ROWS - 1) - k_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    out_valid = 1'b0;
    busy      = 1'b1;
    mac_en    = 1'b0;
    acc_clr   = 1'b0;
    case (state_q)
      S_RUN: begin
        busy   = 1'b0;
        mac_en = 1'b1;
        if (drain_req) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        mac_en  = 1'b1;
        k_d     = '0;
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        k_d = k_q + 1'b1;
        if (k_q == RW'(ROWS - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_clr = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      k_q     <= '0;
      for (int unsigned c = 0; c < COLS; c++) preg_q[c] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      for (int unsigned c = 0; c < COLS; c++) begin
        case (state_q)
          S_FLUSH:  preg_q[c] <= psum_in[c*PSUM_W +: PSUM_W];
          S_REDUCE: preg_q[c] <= preg_q[c] + acc_q[red_row][c];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    psum_out = '0;
    for (int unsigned c = 0; c < COLS; c++) psum_out[c*PSUM_W +: PSUM_W] = preg_q[c];
  end

  // A full slot always blocks its bus, so a fill can never coincide with the MAC
  // consuming that PE's slots; the fill path lives in the else-branch for that reason.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          row_id_q[r][c] <= ID_W'(r);
          col_id_q[r][c] <= ID_W'(c);
          w_full_q[r][c] <= 1'b0;
          i_full_q[r][c] <= 1'b0;
          w_data_q[r][c] <= '0;
          i_data_q[r][c] <= '0;
          acc_q[r][c]    <= '0;
        end
      end
    end else begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (cfg_we && (cfg_r == RW'(r)) && (cfg_c == CW'(c))) begin
            row_id_q[r][c] <= cfg_row_id;
            col_id_q[r][c] <= cfg_col_id;
          end
          if (mac_en && w_full_q[r][c] && i_full_q[r][c]) begin
            acc_q[r][c]    <= acc_q[r][c] + prod[r][c];
            w_full_q[r][c] <= 1'b0;
            i_full_q[r][c] <= 1'b0;
          end else begin
            if (w_fire && w_match[r][c]) begin
              w_full_q[r][c] <= 1'b1;
              w_data_q[r][c] <= w_data;
            end
            if (i_fire && i_match[r][c]) begin
              i_full_q[r][c] <= 1'b1;
              i_data_q[r][c] <= i_data;
            end
          end
          if (acc_clr) acc_q[r][c] <= '0;
        end
      end
    end
  end

`ifdef PE_GRID_DROP_CNT_EN
  logic [15:0] drop_q;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(w_fire & ~w_any) + 17'(i_fire & ~i_any);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = w_any ^ i_any;
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_pe_grid_mc.sv
// Scoreboard bench for pe_grid_mc: expected psum vectors are queued as stimulus is
// driven and popped when the grid presents its reduced output.
module tb_pe_grid_mc;
  localparam int ROWS   = 12;
  localparam int COLS   = 14;
  localparam int DATA_W = 16;
  localparam int PSUM_W = 32;
  localparam int ID_W   = 4;
  localparam int RW     = 4;
  localparam int CW     = 4;
  localparam int VW     = COLS * PSUM_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [RW-1:0]     cfg_r = '0;
  logic [CW-1:0]     cfg_c = '0;
  logic [ID_W-1:0]   cfg_row_id = '0, cfg_col_id = '0;
  logic              w_valid = 1'b0, w_ready;
  logic [DATA_W-1:0] w_data = '0;
  logic [ID_W-1:0]   w_row_tag = '0, w_col_tag = '0;
  logic              i_valid = 1'b0, i_ready;
  logic [DATA_W-1:0] i_data = '0;
  logic [ID_W-1:0]   i_row_tag = '0, i_col_tag = '0;
  logic              drain_req = 1'b0;
  logic [VW-1:0]     psum_in = '0;
  logic [VW-1:0]     psum_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [15:0]       drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] sb_q [$];

  pe_grid_mc #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_r(cfg_r), .cfg_c(cfg_c),
    .cfg_row_id(cfg_row_id), .cfg_col_id(cfg_col_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_row_tag(w_row_tag), .w_col_tag(w_col_tag),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_row_tag(i_row_tag), .i_col_tag(i_col_tag),
    .drain_req(drain_req), .psum_in(psum_in), .psum_out(psum_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic send_w(input logic [DATA_W-1:0] d, input logic [ID_W-1:0] rt, input logic [ID_W-1:0] ct);
    int n;
    n = 0;
    w_valid = 1'b1; w_data = d; w_row_tag = rt; w_col_tag = ct;
    while (w_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (w_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_w_timeout: w_ready=%b after %0d cycles, want 1", w_ready, n);
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_i(input logic [DATA_W-1:0] d, input logic [ID_W-1:0] rt, input logic [ID_W-1:0] ct);
    int n;
    n = 0;
    i_valid = 1'b1; i_data = d; i_row_tag = rt; i_col_tag = ct;
    while (i_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (i_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_i_timeout: i_ready=%b after %0d cycles, want 1", i_ready, n);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_wi(input logic [DATA_W-1:0] wd, input logic [ID_W-1:0] wr, input logic [ID_W-1:0] wc,
                         input logic [DATA_W-1:0] id, input logic [ID_W-1:0] ir, input logic [ID_W-1:0] ic);
    int n;
    n = 0;
    w_valid = 1'b1; w_data = wd; w_row_tag = wr; w_col_tag = wc;
    i_valid = 1'b1; i_data = id; i_row_tag = ir; i_col_tag = ic;
    while (!(w_ready === 1'b1 && i_ready === 1'b1) && n < 50) begin @(posedge clk); #1; n++; end
    if (!(w_ready === 1'b1 && i_ready === 1'b1)) begin
      n_cmp++; n_err++;
      $display("FAIL send_wi_timeout: w_ready=%b i_ready=%b after %0d cycles, want 1/1", w_ready, i_ready, n);
    end
    @(posedge clk); #1;
    w_valid = 1'b0; i_valid = 1'b0;
  endtask

  task automatic do_drain(input logic [VW-1:0] pin, input int hold,
                          output logic [VW-1:0] got, output int lat, output bit stable, output bit quiet);
    psum_in = pin;
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < ROWS + 40) begin @(posedge clk); #1; lat++; end
    got = psum_out;
    stable = 1'b1;
    quiet = (w_ready === 1'b0) && (i_ready === 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (psum_out !== got || out_valid !== 1'b1) stable = 1'b0;
      if (w_ready !== 1'b0 || i_ready !== 1'b0) quiet = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
    n_cmp++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (psum_out !== '0) begin n_err++; $display("FAIL reset_psum_out: got %h want 0", psum_out); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (w_ready !== 1'b1 || i_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_ready: got w=%b i=%b want 1/1", w_ready, i_ready);
    end
  endtask

  task automatic test_unicast();
    logic [VW-1:0] e, got;
    int lat; bit st, qt;
    send_w(16'd3, 4'd2, 4'd5);
    send_i(16'd4, 4'd2, 4'd5);
    e = '0; e[5*PSUM_W +: PSUM_W] = 32'd12;
    sb_q.push_back(e);
    do_drain('0, 0, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (lat !== ROWS + 2) begin n_err++; $display("FAIL unicast_latency: got %0d want %0d", lat, ROWS + 2); end
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL unicast_psum: got %h want %h", got, e); end
  endtask

  task automatic test_broadcast();
    logic [VW-1:0] e, got, pin;
    int lat; bit st, qt;
    send_w(-16'sd2, 4'hF, 4'd0);
    send_i(16'd7, 4'hF, 4'd0);
    pin = '0;
    pin[0 +: PSUM_W] = 32'd100;
    for (int c = 1; c < COLS; c++) pin[c*PSUM_W +: PSUM_W] = 32'(c * 1000);
    e = pin;
    e[0 +: PSUM_W] = 32'(100 + ROWS * (-2 * 7));
    sb_q.push_back(e);
    do_drain(pin, 0, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL broadcast_psum: got %h want %h", got, e); end
    n_cmp++; if (got[0 +: PSUM_W] !== 32'hFFFF_FFBC) begin
      n_err++; $display("FAIL broadcast_col0: got %h want ffffffbc", got[0 +: PSUM_W]);
    end
  endtask

  task automatic test_remap();
    logic [VW-1:0] e, got;
    logic [15:0] exp_drop;
    int lat; bit st, qt;
    cfg_valid = 1'b1; cfg_r = 4'd0; cfg_c = 4'd3; cfg_row_id = 4'd9; cfg_col_id = 4'd9;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    send_w(16'd5, 4'd9, 4'd9);
    send_i(16'd6, 4'd9, 4'd9);
    send_w(16'd11, 4'd0, 4'd3);
    send_i(16'd13, 4'd0, 4'd3);
`ifdef PE_GRID_DROP_CNT_EN
    exp_drop = 16'd2;
`else
    exp_drop = 16'd0;
`endif
    n_cmp++; if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL remap_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    // Remapped PE(0,3) and identity PE(9,9) both carry IDs (9,9).
    e = '0;
    e[3*PSUM_W +: PSUM_W] = 32'd30;
    e[9*PSUM_W +: PSUM_W] = 32'd30;
    sb_q.push_back(e);
    do_drain('0, 0, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL remap_psum: got %h want %h", got, e); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] e, got;
    int lat; bit st, qt, held;
    send_w(16'd2, 4'd1, 4'd1);
    w_valid = 1'b1; w_data = 16'd9; w_row_tag = 4'd1; w_col_tag = 4'd1;
    held = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (w_ready !== 1'b0) held = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL bp_w_ready_held: got ready seen, want 0 for 3 cycles"); end
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL bp_i_ready: got %b want 1", i_ready); end
    i_valid = 1'b1; i_data = 16'd5; i_row_tag = 4'd1; i_col_tag = 4'd1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL bp_w_ready_pre_mac: got %b want 0", w_ready); end
    @(posedge clk); #1;
    n_cmp++; if (w_ready !== 1'b1) begin n_err++; $display("FAIL bp_w_ready_post_mac: got %b want 1", w_ready); end
    @(posedge clk); #1;
    w_valid = 1'b0;
    send_i(16'd3, 4'd1, 4'd1);
    e = '0; e[1*PSUM_W +: PSUM_W] = 32'(2 * 5 + 9 * 3);
    sb_q.push_back(e);
    do_drain('0, 0, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL bp_psum: got %h want %h", got, e); end
  endtask

  task automatic test_hold_out();
    logic [VW-1:0] e, got;
    int lat; bit st, qt;
    send_wi(16'h8000, 4'd4, 4'd7, 16'h8000, 4'd4, 4'd7);
    send_wi(16'h8000, 4'd4, 4'd7, 16'h8000, 4'd4, 4'd7);
    e = '0; e[7*PSUM_W +: PSUM_W] = 32'h8000_0000;
    sb_q.push_back(e);
    do_drain('0, 5, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (lat !== ROWS + 2) begin n_err++; $display("FAIL hold_latency: got %0d want %0d", lat, ROWS + 2); end
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL hold_psum: got %h want %h", got, e); end
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL hold_stable: got %b want 1", st); end
    n_cmp++; if (qt !== 1'b1) begin n_err++; $display("FAIL hold_readies_low: got %b want 1", qt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_busy_after: got %b want 0", busy); end
    sb_q.push_back('0);
    do_drain('0, 0, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL cleared_acc_psum: got %h want %h", got, e); end
  endtask

  task automatic test_reset_mid_pass();
    logic [VW-1:0] e, got;
    int lat; bit st, qt;
    send_wi(16'd4, 4'd5, 4'd5, 16'd4, 4'd5, 4'd5);
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (w_ready !== 1'b0) begin n_err++; $display("FAIL midrst_w_ready: got %b want 0", w_ready); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_drop_cnt: got %0d want 0", drop_cnt); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send_wi(16'd6, 4'd0, 4'd3, 16'd7, 4'd0, 4'd3);
    e = '0; e[3*PSUM_W +: PSUM_W] = 32'd42;
    sb_q.push_back(e);
    do_drain('0, 0, got, lat, st, qt);
    e = sb_q.pop_front();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL midrst_psum: got %h want %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_remap();
    test_backpressure();
    test_hold_out();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
